// File: rtl/maze_walker.sv
// rtl/maze_walker.sv - one-actor grid walker reading maze rows from a 32x32 map ROM
// Optional edge wrap-around enabled by defining MAZE_WALKER_WRAP_EN.
module maze_walker #(
    parameter logic [4:0] START_X   = 5'd13,
    parameter logic [4:0] START_Y   = 5'd24,
    parameter logic [1:0] START_DIR = 2'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        dir_valid,
    input  logic [1:0]  dir_req,
    output logic [4:0]  row_addr,
    input  logic [31:0] row_bits,
    output logic [4:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [1:0]  dir,
    output logic        busy,
    output logic        blocked
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_P = 3'd1;
    localparam logic [2:0] S_CHECK_P = 3'd2;
    localparam logic [2:0] S_FETCH_C = 3'd3;
    localparam logic [2:0] S_CHECK_C = 3'd4;

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_UP    = 2'd3;

    logic [2:0] state_q, state_d;
    logic [4:0] pos_x_q, pos_x_d;
    logic [4:0] pos_y_q, pos_y_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] mdir_q, mdir_d;
    logic       blocked_q, blocked_d;

    logic [1:0] eval_dir;
    logic [4:0] tgt_x;
    logic [4:0] tgt_y;
    logic [4:0] bit_idx;
    logic       off_grid;
    logic       cell_wall;

    // The fallback states evaluate the current heading; the first pass uses the
    // direction latched when the tick was accepted.
    always_comb begin
        eval_dir = ((state_q == S_FETCH_C) || (state_q == S_CHECK_C)) ? dir_q : mdir_q;
        tgt_x    = pos_x_q;
        tgt_y    = pos_y_q;
        case (eval_dir)
            D_RIGHT: tgt_x = pos_x_q + 5'd1;
            D_DOWN:  tgt_y = pos_y_q + 5'd1;
            D_LEFT:  tgt_x = pos_x_q - 5'd1;
            default: tgt_y = pos_y_q - 5'd1;
        endcase
    end

`ifdef MAZE_WALKER_WRAP_EN
    assign off_grid = 1'b0;
`else
    assign off_grid = ((eval_dir == D_RIGHT) && (pos_x_q == 5'd31)) ||
                      ((eval_dir == D_DOWN)  && (pos_y_q == 5'd31)) ||
                      ((eval_dir == D_LEFT)  && (pos_x_q == 5'd0))  ||
                      ((eval_dir == D_UP)    && (pos_y_q == 5'd0));
`endif

    assign bit_idx   = 5'd31 - tgt_x;
    assign cell_wall = off_grid | row_bits[bit_idx];

    always_comb begin
        row_addr = pos_y_q;
        if ((state_q != S_IDLE) && !off_grid) begin
            row_addr = tgt_y;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        mdir_d    = mdir_q;
        blocked_d = 1'b0;
        pend_d    = dir_valid ? dir_req : pend_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_FETCH_P;
                    mdir_d  = dir_valid ? dir_req : pend_q;
                end
            end
            S_FETCH_P: state_d = S_CHECK_P;
            S_CHECK_P: begin
                if (!cell_wall) begin
                    pos_x_d = tgt_x;
                    pos_y_d = tgt_y;
                    dir_d   = mdir_q;
                    state_d = S_IDLE;
                end else if (mdir_q == dir_q) begin
                    blocked_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_FETCH_C;
                end
            end
            S_FETCH_C: state_d = S_CHECK_C;
            S_CHECK_C: begin
                if (!cell_wall) begin
                    pos_x_d = tgt_x;
                    pos_y_d = tgt_y;
                end else begin
                    blocked_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pos_x_q   <= START_X;
            pos_y_q   <= START_Y;
            dir_q     <= START_DIR;
            pend_q    <= START_DIR;
            mdir_q    <= START_DIR;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            mdir_q    <= mdir_d;
            blocked_q <= blocked_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign busy    = (state_q != S_IDLE);
    assign blocked = blocked_q;

endmodule

// File: tb/tb_maze_walker.sv
// tb/tb_maze_walker.sv - self-checking bench for maze_walker (MAZE_WALKER_WRAP_EN aware)
module tb_maze_walker;

    logic        clk = 1'b0;
    logic        reset_n, tick, dir_valid;
    logic [1:0]  dir_req;
    logic [4:0]  row_addr, pos_x, pos_y;
    logic [31:0] row_bits;
    logic [1:0]  dir;
    logic        busy, blocked;

    logic        tick2;
    logic [4:0]  row_addr2, pos_x2, pos_y2;
    logic [1:0]  dir2;
    logic        busy2, blocked2;

    logic [31:0] maze [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign row_bits = maze[row_addr];

    maze_walker u_dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .dir_valid(dir_valid),
        .dir_req(dir_req), .row_addr(row_addr), .row_bits(row_bits),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .busy(busy), .blocked(blocked)
    );

    maze_walker #(.START_X(5'd0), .START_Y(5'd24), .START_DIR(2'd2)) u_edge (
        .clk(clk), .reset_n(reset_n), .tick(tick2), .dir_valid(1'b0),
        .dir_req(2'b00), .row_addr(row_addr2), .row_bits(32'h0000_0000),
        .pos_x(pos_x2), .pos_y(pos_y2), .dir(dir2), .busy(busy2), .blocked(blocked2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: decides the whole move outcome at tick time from the map.
    function automatic void target(input int x, input int y, input int d,
                                   output int tx, output int ty, output bit off);
        tx = x; ty = y; off = 1'b0;
        case (d)
            0: tx = x + 1;
            1: ty = y + 1;
            2: tx = x - 1;
            default: ty = y - 1;
        endcase
        if (tx < 0 || tx > 31 || ty < 0 || ty > 31) begin
`ifdef MAZE_WALKER_WRAP_EN
            tx = (tx + 32) % 32;
            ty = (ty + 32) % 32;
`else
            off = 1'b1;
`endif
        end
    endfunction

    function automatic bit is_wall(input int tx, input int ty, input bit off);
        if (off) return 1'b1;
        return maze[ty][31 - tx];
    endfunction

    int m_x, m_y, m_dir, m_pend, m_ph, m_len, m_ra1, m_ra2;
    int r_x, r_y, r_dir;
    bit r_blk, m_blk;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int ed, tx, ty;
        bit off, wall;
        m_blk = 1'b0;
        if (!reset_n) begin
            m_x = 13; m_y = 24; m_dir = 2; m_pend = 2; m_ph = 0; m_valid = 1'b1;
        end else begin
            if (m_ph != 0) begin
                m_ph++;
                if (m_ph == m_len) begin
                    m_x = r_x; m_y = r_y; m_dir = r_dir; m_blk = r_blk; m_ph = 0;
                end
            end else if (tick) begin
                ed = dir_valid ? int'(dir_req) : m_pend;
                target(m_x, m_y, ed, tx, ty, off);
                wall  = is_wall(tx, ty, off);
                m_ra1 = off ? m_y : ty;
                m_ra2 = m_y;
                m_ph  = 1; m_len = 3;
                r_x = m_x; r_y = m_y; r_dir = m_dir; r_blk = 1'b0;
                if (!wall) begin
                    r_x = tx; r_y = ty; r_dir = ed;
                end else if (ed == m_dir) begin
                    r_blk = 1'b1;
                end else begin
                    m_len = 5;
                    target(m_x, m_y, m_dir, tx, ty, off);
                    wall  = is_wall(tx, ty, off);
                    m_ra2 = off ? m_y : ty;
                    if (!wall) begin
                        r_x = tx; r_y = ty;
                    end else begin
                        r_blk = 1'b1;
                    end
                end
            end
            if (dir_valid) m_pend = dir_req;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pos_x", pos_x, m_x);
            chk("model_pos_y", pos_y, m_y);
            chk("model_dir", dir, m_dir);
            chk("model_busy", busy, m_ph != 0);
            chk("model_blocked", blocked, m_blk);
            chk("model_row_addr", row_addr, (m_ph == 0) ? m_y : ((m_ph <= 2) ? m_ra1 : m_ra2));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
    endtask

    // Leaves the caller in cycle T+1 of the tick.
    task automatic pulse(input bit dv, input logic [1:0] dr);
        @(posedge clk); #1;
        tick = 1'b1; dir_valid = dv; dir_req = dr;
        @(posedge clk); #1;
        tick = 1'b0; dir_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) maze[r] = 32'hFFFF_FFFF;
        for (int x = 7; x <= 20; x++) maze[24][31 - x] = 1'b0;
        maze[23][31 - 13] = 1'b0;
        maze[25][31 - 12] = 1'b0;

        reset_n = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_req = 2'd0; tick2 = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        chk("reset_pos_x", pos_x, 13);
        chk("reset_pos_y", pos_y, 24);
        chk("reset_dir", dir, 2);
        chk("reset_busy", busy, 0);
        chk("reset_blocked", blocked, 0);
        chk("reset_row_addr", row_addr, 24);

        for (int i = 0; i < 6; i++) begin
            pulse(1'b0, 2'd0);
            chk("plain_busy_t1", busy, 1);
            wait_cycles(1);
            chk("plain_pos_x_t2", pos_x, 13 - i);
            wait_cycles(1);
            chk("plain_pos_x_t3", pos_x, 12 - i);
            chk("plain_pos_y_t3", pos_y, 24);
        end
        pulse(1'b0, 2'd0);
        wait_cycles(2);
        chk("wall_blocked_t3", blocked, 1);
        chk("wall_pos_x", pos_x, 7);
        wait_cycles(1);
        chk("wall_blocked_t4", blocked, 0);

        do_reset();
        @(posedge clk); #1;
        dir_valid = 1'b1; dir_req = 2'd1;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        pulse(1'b0, 2'd0);
        wait_cycles(3);
        chk("fb_busy_t4", busy, 1);
        wait_cycles(1);
        chk("fb_pos_x", pos_x, 12);
        chk("fb_pos_y", pos_y, 24);
        chk("fb_dir", dir, 2);
        chk("fb_blocked", blocked, 0);
        pulse(1'b0, 2'd0);
        wait_cycles(2);
        chk("retry_pos_x", pos_x, 12);
        chk("retry_pos_y", pos_y, 25);
        chk("retry_dir", dir, 1);

        do_reset();
        pulse(1'b1, 2'd3);
        wait_cycles(2);
        chk("turn_pos_x", pos_x, 13);
        chk("turn_pos_y", pos_y, 23);
        chk("turn_dir", dir, 3);

        do_reset();
        pulse(1'b0, 2'd0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        wait_cycles(1);
        chk("ign_pos_x_t3", pos_x, 12);
        wait_cycles(4);
        chk("ign_pos_x_later", pos_x, 12);
        chk("ign_busy", busy, 0);

        do_reset();
        pulse(1'b0, 2'd0);
        wait_cycles(1);
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        chk("rst_mid_pos_x", pos_x, 13);
        chk("rst_mid_blocked", blocked, 0);
        wait_cycles(3);
        chk("rst_mid_pos_x_later", pos_x, 13);
        chk("rst_mid_blocked_later", blocked, 0);

        do_reset();
        @(posedge clk); #1;
        tick2 = 1'b1;
        @(posedge clk); #1;
        tick2 = 1'b0;
        chk("edge_busy_t1", busy2, 1);
        wait_cycles(2);
`ifdef MAZE_WALKER_WRAP_EN
        chk("edge_pos_x", pos_x2, 31);
        chk("edge_blocked", blocked2, 0);
`else
        chk("edge_pos_x", pos_x2, 0);
        chk("edge_blocked", blocked2, 1);
`endif
        chk("edge_pos_y", pos_y2, 24);
        chk("edge_busy_t3", busy2, 0);

        wait_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
